// File: rtl/ring_osc_monitor.sv
// Multi-channel ring-oscillator frequency monitor.
// Each channel counts synchronised rising edges of its oscillator over a gate window of
// 2^GATE_LOG2 clocks, optionally averaging four windows, and raises a per-channel warning
// with hysteresis: a low count (slow oscillator) means hot.
module ring_osc_monitor #(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned CW        = 8,
    parameter int unsigned GATE_LOG2 = 10
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   en,
    input  logic                                   avg_mode,
    input  logic [N_CH-1:0]                        osc_in,
    input  logic [CW-1:0]                          thr_hot,
    input  logic [CW-1:0]                          thr_cold,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
    output logic [CW-1:0]                          result_out,
    output logic                                   result_valid,
    output logic [N_CH-1:0]                        warn,
    output logic                                   warn_any
);

    typedef enum logic [1:0] {
        StIdle,
        StGate,
        StUpdate
    } state_e;

    state_e state_q, state_d;

    // Input synchronisers and edge detection
    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;
    logic [N_CH-1:0] prev_q;
    logic [N_CH-1:0] edge_pulse;

    // Shared measurement control
    logic [GATE_LOG2-1:0] gate_cnt_q;
    logic [1:0]           win_idx_q;
    logic                 avg_q;
    logic                 valid_q;
    logic                 gate_last;

    // Decoded FSM controls
    logic in_idle;
    logic in_gate;
    logic in_update;
    logic latch;

    // Per-channel results gathered for the readout mux
    logic [CW-1:0] res_w [N_CH];

    // Two-flop synchroniser followed by a previous-value flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= osc_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edge_pulse = sync2_q & ~prev_q;
    assign gate_last  = (gate_cnt_q == '1);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: dropping en during a gate window aborts straight to idle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StGate;
                end
            end
            StGate: begin
                if (!en) begin
                    state_d = StIdle;
                end else if (gate_last) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                state_d = en ? StGate : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs: per-state control strobes for the datapath
    always_comb begin
        in_idle   = 1'b0;
        in_gate   = 1'b0;
        in_update = 1'b0;
        unique case (state_q)
            StIdle:   in_idle   = 1'b1;
            StGate:   in_gate   = 1'b1;
            StUpdate: in_update = 1'b1;
            default:  in_idle   = 1'b1;
        endcase
    end

    // Results latch on every update in single mode, only on the fourth when averaging
    assign latch = in_update && (!avg_q || (win_idx_q == 2'd3));

    // Gate counter, averaging window index, captured mode and the result_valid pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gate_cnt_q <= '0;
            win_idx_q  <= '0;
            avg_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            gate_cnt_q <= in_gate ? (gate_cnt_q + GATE_LOG2'(1)) : '0;
            if (in_idle) begin
                win_idx_q <= '0;
            end else if (in_update && avg_q) begin
                win_idx_q <= win_idx_q + 2'd1;
            end
            // Mode is frozen for the whole run so an average never mixes modes
            if (in_idle && en) begin
                avg_q <= avg_mode;
            end
            valid_q <= latch;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CW-1:0]   cnt_q;
        logic [CW+1:0]   acc_q;
        logic [CW+1:0]   sum;
        logic [CW-1:0]   new_res;
        logic [CW-1:0]   res_q;
        logic            warn_q;
        logic            warn_d;

        // On the last averaging update the accumulator holds three windows; add the fourth
        assign sum     = acc_q + {2'b00, cnt_q};
        assign new_res = avg_q ? CW'(sum >> 2) : cnt_q;

        // Hysteresis on the candidate result; set wins when thresholds overlap
        always_comb begin
            warn_d = warn_q;
            if (new_res <= thr_hot) begin
                warn_d = 1'b1;
            end else if (new_res >= thr_cold) begin
                warn_d = 1'b0;
            end
        end

        // Saturating edge counter, live only during gate cycles
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (!in_gate) begin
                cnt_q <= '0;
            end else if (edge_pulse[g] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end

        // Four-window accumulator; idle discards any partial average
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc_q <= '0;
            end else if (in_idle) begin
                acc_q <= '0;
            end else if (in_update && avg_q) begin
                acc_q <= (win_idx_q == 2'd3) ? '0 : sum;
            end
        end

        // Result and warning registers survive aborts; only a latch updates them
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                res_q  <= '0;
                warn_q <= 1'b0;
            end else if (latch) begin
                res_q  <= new_res;
                warn_q <= warn_d;
            end
        end

        assign res_w[g] = res_q;
        assign warn[g]  = warn_q;
    end

    // Readout mux; an out-of-range channel select reads as zero
    always_comb begin
        result_out = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (32'(ch_sel) == i) begin
                result_out = res_w[i];
            end
        end
    end

    assign result_valid = valid_q;
    assign warn_any     = |warn;

endmodule
